// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the PLL-domain reset. Retries bounded attempts and counts lock losses.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       restart_i,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] loss_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam logic [15:0] RST_LAST = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [15:0] STB_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  MAX_R    = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic        lost_d;
  logic        sync1_q, sync2_q;
  logic        lock_s;

  assign lock_s = sync2_q;

  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    lost_d  = 1'b0;
    // restart overrides every other transition, including a RUN lock loss
    if (restart_i) begin
      state_d = S_RESET_PLL;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q == MAX_R) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = S_RESET_PLL;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s)                state_d = S_WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_RESET_PLL;
            lost_d  = 1'b1;
            retry_d = 4'd0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET_PLL;
      endcase
    end
    // counter restarts on every state entry, including restart re-entry
    if (restart_i || (state_d != state_q))             cnt_d = 16'd0;
    else if ((state_q == S_RUN) || (state_q == S_FAIL)) cnt_d = cnt_q;
    else                                               cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge refclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= 16'd0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      pll_rst_o   <= 1'b1;
      sys_rst_o   <= 1'b1;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_o   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_o   <= (state_d != S_RUN);
      ready_o     <= (state_d == S_RUN);
      fail_o      <= (state_d == S_FAIL);
      lock_lost_o <= lost_d;
    end
  end

  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters; edge 1 is
// the first rising edge after reset release.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .refclk_i(clk), .rst_i(rst), .restart_i(restart), .pll_locked_i(pll_locked),
    .pll_rst_o(pll_rst), .sys_rst_o(sys_rst), .ready_o(ready), .fail_o(fail),
    .lock_lost_o(lock_lost), .retry_cnt_o(retry_cnt), .loss_cnt_o(loss_cnt),
    .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic go_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    restart = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if ({pll_rst, sys_rst, ready, fail, lock_lost} !== 5'b11000) begin
      failures++; $display("FAIL rst_flags got=%b exp=11000", {pll_rst, sys_rst, ready, fail, lock_lost}); end
    checks++; if ({retry_cnt, loss_cnt} !== 12'h000) begin
      failures++; $display("FAIL rst_counts got=%h exp=000", {retry_cnt, loss_cnt}); end
  endtask

  task automatic test_nominal();
    apply_reset();
    go_to(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL nom_prst_e3 got=%b exp=1", pll_rst); end
    go_to(4);
    checks++; if ({pll_rst, sys_rst} !== 2'b01) begin failures++; $display("FAIL nom_prst_e4 got=%b exp=01", {pll_rst, sys_rst}); end
    go_to(9);
    pll_locked = 1'b1;
    go_to(11);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL nom_wait_e11 got=%0d exp=1", state); end
    go_to(12);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL nom_stable_e12 got=%0d exp=2", state); end
    go_to(19);
    checks++; if ({ready, sys_rst} !== 2'b01) begin failures++; $display("FAIL nom_e19 got=%b exp=01", {ready, sys_rst}); end
    go_to(20);
    checks++; if ({ready, sys_rst, pll_rst} !== 3'b100) begin failures++; $display("FAIL nom_run_e20 got=%b exp=100", {ready, sys_rst, pll_rst}); end
    go_to(22);
    restart = 1'b1;
    go_to(23);
    restart = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL run_restart_state got=%0d exp=0", state); end
    checks++; if ({ready, sys_rst, pll_rst, lock_lost} !== 4'b0110) begin
      failures++; $display("FAIL run_restart_flags got=%b exp=0110", {ready, sys_rst, pll_rst, lock_lost}); end
    checks++; if (loss_cnt !== 8'd0) begin failures++; $display("FAIL run_restart_loss got=%0d exp=0", loss_cnt); end
    go_to(24);
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL run_restart_nolost got=%b exp=0", lock_lost); end
    go_to(27);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL restart_wait_e27 got=%0d exp=1", state); end
    go_to(35);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL restart_e35 got=%b exp=0", ready); end
    go_to(36);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL restart_run_e36 got=%b exp=1", ready); end
  endtask

  task automatic test_no_lock_and_restart();
    apply_reset();
    go_to(23);
    checks++; if ({state, retry_cnt, pll_rst} !== {3'd1, 4'd0, 1'b0}) begin
      failures++; $display("FAIL nl_e23 got=%0d/%0d/%b exp=1/0/0", state, retry_cnt, pll_rst); end
    go_to(24);
    checks++; if ({pll_rst, retry_cnt} !== {1'b1, 4'd1}) begin
      failures++; $display("FAIL nl_retry1_e24 got=%b/%0d exp=1/1", pll_rst, retry_cnt); end
    go_to(27);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL nl_e27 got=%b exp=1", pll_rst); end
    go_to(28);
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL nl_e28 got=%b exp=0", pll_rst); end
    go_to(48);
    checks++; if ({pll_rst, retry_cnt} !== {1'b1, 4'd2}) begin
      failures++; $display("FAIL nl_retry2_e48 got=%b/%0d exp=1/2", pll_rst, retry_cnt); end
    go_to(52);
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL nl_e52 got=%b exp=0", pll_rst); end
    go_to(71);
    checks++; if (fail !== 1'b0) begin failures++; $display("FAIL nl_e71 got=%b exp=0", fail); end
    go_to(72);
    checks++; if ({fail, pll_rst, sys_rst, ready, retry_cnt} !== {4'b1110, 4'd2}) begin
      failures++; $display("FAIL nl_fail_e72 got=%b/%0d exp=1110/2", {fail, pll_rst, sys_rst, ready}, retry_cnt); end
    go_to(100);
    checks++; if ({fail, state} !== {1'b1, 3'd4}) begin failures++; $display("FAIL nl_hold_e100 got=%b/%0d exp=1/4", fail, state); end
    restart = 1'b1;
    go_to(101);
    restart = 1'b0;
    checks++; if ({fail, retry_cnt, state, pll_rst} !== {1'b0, 4'd0, 3'd0, 1'b1}) begin
      failures++; $display("FAIL fail_restart got=%b/%0d/%0d/%b exp=0/0/0/1", fail, retry_cnt, state, pll_rst); end
    go_to(105);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL fail_restart_wait got=%0d exp=1", state); end
  endtask

  task automatic test_restart_timeout();
    apply_reset();
    go_to(23);
    restart = 1'b1;
    go_to(24);
    restart = 1'b0;
    checks++; if ({state, retry_cnt} !== {3'd0, 4'd0}) begin
      failures++; $display("FAIL rt_e24 got=%0d/%0d exp=0/0", state, retry_cnt); end
    go_to(28);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rt_wait_e28 got=%0d exp=1", state); end
    go_to(47);
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL rt_e47 got=%0d exp=0", retry_cnt); end
    go_to(48);
    checks++; if (retry_cnt !== 4'd1) begin failures++; $display("FAIL rt_e48 got=%0d exp=1", retry_cnt); end
  endtask

  task automatic test_glitch();
    apply_reset();
    go_to(9);
    pll_locked = 1'b1;
    go_to(12);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL gl_stable_e12 got=%0d exp=2", state); end
    go_to(14);
    pll_locked = 1'b0;
    go_to(16);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL gl_e16 got=%0d exp=2", state); end
    go_to(17);
    pll_locked = 1'b1;
    checks++; if ({state, retry_cnt} !== {3'd1, 4'd0}) begin
      failures++; $display("FAIL gl_wait_e17 got=%0d/%0d exp=1/0", state, retry_cnt); end
    go_to(19);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL gl_e19 got=%0d exp=1", state); end
    go_to(20);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL gl_stable_e20 got=%0d exp=2", state); end
    go_to(27);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL gl_e27 got=%b exp=0", ready); end
    go_to(28);
    checks++; if ({ready, retry_cnt} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL gl_run_e28 got=%b/%0d exp=1/0", ready, retry_cnt); end
  endtask

  task automatic test_loss();
    apply_reset();
    go_to(9);
    pll_locked = 1'b1;
    go_to(24);
    pll_locked = 1'b0;
    go_to(26);
    checks++; if ({ready, lock_lost} !== 2'b10) begin failures++; $display("FAIL loss_e26 got=%b exp=10", {ready, lock_lost}); end
    go_to(27);
    checks++; if ({lock_lost, sys_rst, pll_rst, ready} !== 4'b1110) begin
      failures++; $display("FAIL loss_e27 got=%b exp=1110", {lock_lost, sys_rst, pll_rst, ready}); end
    checks++; if ({loss_cnt, retry_cnt, state} !== {8'd1, 4'd0, 3'd0}) begin
      failures++; $display("FAIL loss_cnt_e27 got=%0d/%0d/%0d exp=1/0/0", loss_cnt, retry_cnt, state); end
    go_to(28);
    pll_locked = 1'b1;
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL loss_pulse_e28 got=%b exp=0", lock_lost); end
    go_to(40);
    checks++; if ({ready, loss_cnt} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL loss_rerun_e40 got=%b/%0d exp=1/1", ready, loss_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({state, ready, lock_lost, pll_rst, loss_cnt} !== {3'd0, 3'b001, 8'd0}) begin
      failures++; $display("FAIL async_rst_run got=%0d/%b/%0d exp=0/001/0", state, {ready, lock_lost, pll_rst}, loss_cnt); end
    pll_locked = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({lock_lost, loss_cnt} !== {1'b0, 8'd0}) begin
      failures++; $display("FAIL async_rst_nolost got=%b/%0d exp=0/0", lock_lost, loss_cnt); end
  endtask

  task automatic test_loss_saturate();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      for (int k = 0; k < 40 && !ready; k++) begin @(posedge clk); #1; end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL sat_ready_timeout iter=%0d got=%b exp=1", i, ready); end
      pll_locked = 1'b0;
      for (int k = 0; k < 10 && !lock_lost; k++) begin @(posedge clk); #1; end
      checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL sat_lost_timeout iter=%0d got=%b exp=1", i, lock_lost); end
      if (i == 254) begin
        checks++; if (loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", loss_cnt); end
      end
    end
    checks++; if (loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", loss_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_lock_and_restart();
    test_restart_timeout();
    test_glitch();
    test_loss();
    test_loss_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
